// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column types, MixColumns mode encoding,
// request payload struct and GF(2^8) helpers (xtime, gmul).
package aes_pkg;

  localparam int unsigned AES_NB   = 4;
  localparam logic [7:0]  AES_POLY = 8'h1b;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = AES_NB * COL_W;
  localparam int unsigned MODE_W   = 2;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [MODE_W-1:0]  mode_t;

  // Mode 3 is reserved and falls through to bypass wherever modes are decoded.
  localparam mode_t MC_FWD = 2'd0;
  localparam mode_t MC_INV = 2'd1;
  localparam mode_t MC_BYP = 2'd2;

  // State and mode captured together at accept.
  typedef struct packed {
    state_t state;
    mode_t  mode;
  } mc_req_t;

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by the small constants MixColumns/InvMixColumns need.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8, r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'h2:    r = x2;
      4'h3:    r = x2 ^ a;
      4'h9:    r = x8 ^ a;
      4'hb:    r = x8 ^ x2 ^ a;
      4'hd:    r = x8 ^ x4 ^ a;
      4'he:    r = x8 ^ x4 ^ x2;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// Valid/ready bus around the MixColumns stage.
//   in_valid/in_ready/in_state/in_mode : upstream (ShiftRows) side
//   out_valid/out_ready/out_state      : downstream (AddRoundKey) side
// slave = the stage itself, master = its environment.
interface mix_columns_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  mode_t  in_mode;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  modport slave (
    input  in_valid, in_state, in_mode, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_mode, out_ready,
    input  in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_column_unit.sv
// Combinational single-column transform.
//   col_in    : column a0..a3, a0 in the top byte
//   mode      : MC_FWD, MC_INV, anything else passes the column through
//   col_out_c : transformed column, same byte order
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t  col_in,
  input  mode_t mode,
  output col_t  col_out_c
);

  // Row r lives at packed index 3-r; the 2-bit truncation wraps r+k mod 4.
  function automatic logic [1:0] ridx(input int unsigned r);
    return 2'(3 - r);
  endfunction

  logic [3:0][7:0] a;
  logic [3:0][7:0] b;

  assign a = col_in;

  always_comb begin
    b = a;
    case (mode)
      MC_FWD: begin
        for (int unsigned r = 0; r < 4; r++) begin
          b[ridx(r)] = gmul(a[ridx(r)], 4'h2) ^ gmul(a[ridx(r + 1)], 4'h3)
                     ^ a[ridx(r + 2)] ^ a[ridx(r + 3)];
        end
      end
      MC_INV: begin
        for (int unsigned r = 0; r < 4; r++) begin
          b[ridx(r)] = gmul(a[ridx(r)], 4'he) ^ gmul(a[ridx(r + 1)], 4'hb)
                     ^ gmul(a[ridx(r + 2)], 4'hd) ^ gmul(a[ridx(r + 3)], 4'h9);
        end
      end
      default: b = a;
    endcase
    col_out_c = b;
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns / InvMixColumns / bypass stage with valid/ready on
// both sides. COLS_PER_CYCLE columns are transformed in place per BUSY cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mix_columns_iter_if.slave (in_* upstream, out_* downstream)
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter int unsigned NB             = AES_NB
) (
  input logic              clk,
  input logic              rst,
  mix_columns_iter_if.slave bus
);

  localparam int unsigned STEPS = NB / COLS_PER_CYCLE;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) || NB != AES_NB) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4 and NB must be 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mc_req_t          req_q, req_d;
  state_t           out_state_q, out_state_d;
  logic             in_ready_q, out_valid_q;

  int unsigned col_idx  [COLS_PER_CYCLE];
  col_t        cols_sel [COLS_PER_CYCLE];
  col_t        cols_mix [COLS_PER_CYCLE];
  state_t      mixed_state;

  // Pick the columns addressed by the step counter.
  always_comb begin
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i]  = 32'(cnt_q) * COLS_PER_CYCLE + i;
      cols_sel[i] = req_q.state[STATE_W - 1 - COL_W * col_idx[i] -: COL_W];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_column_unit u_col (
      .col_in    (cols_sel[g]),
      .mode      (req_q.mode),
      .col_out_c (cols_mix[g])
    );
  end

  // Working state with this step's columns replaced.
  always_comb begin
    mixed_state = req_q.state;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      mixed_state[STATE_W - 1 - COL_W * col_idx[i] -: COL_W] = cols_mix[i];
    end
  end

  // Next-state and datapath-register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    out_state_d = out_state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          req_d.state = bus.in_state;
          req_d.mode  = bus.in_mode;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        req_d.state = mixed_state;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          out_state_d = mixed_state;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      out_state_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      out_state_q <= out_state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;

endmodule
